// File: rtl/cnn_settle_detect.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_settle_detect
//  Purpose  : Detects settling of a 4x4 cellular-network array over sweeps and
//             hands out a frozen binarised result via valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_settle_detect #(
    parameter int DW            = 9,
    parameter int MAX_SWEEPS    = 64,
    parameter int STABLE_SWEEPS = 2,
    parameter int TOL           = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sweep_end,
    input  logic [16*DW-1:0] y_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_bits,
    output logic [7:0]       out_sweeps,
    output logic             out_converged
);

    localparam logic [1:0]  c_idle       = 2'd0;
    localparam logic [1:0]  c_run        = 2'd1;
    localparam logic [1:0]  c_done       = 2'd2;
    localparam logic [7:0]  c_max_sweeps = 8'(MAX_SWEEPS);
    localparam logic [3:0]  c_stable     = 4'(STABLE_SWEEPS);
    localparam logic [DW:0] c_tol        = (DW+1)'(TOL);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [16*DW-1:0] r_snap;
    logic             r_snap_vld;
    logic [7:0]       r_sweep_cnt;
    logic [3:0]       r_stable_cnt;
    logic [15:0]      r_out_bits;
    logic [7:0]       r_out_sweeps;
    logic             r_out_conv;

    logic [15:0]      w_cell_stable;
    logic [15:0]      w_sign_bits;
    logic             w_all_stable;
    logic [3:0]       w_stable_inc;
    logic [3:0]       w_stable_nxt;
    logic [7:0]       w_sweep_nxt;
    logic             w_conv;
    logic             w_limit;
    logic             w_run_sweep;

    // Per-cell change magnitude in DW+1 bits so the full signed range fits.
    for (genvar k = 0; k < 16; k++) begin : g_cell
        logic signed [DW:0] w_diff;
        logic        [DW:0] w_abs;
        assign w_diff = $signed({y_in[(k+1)*DW-1], y_in[k*DW +: DW]})
                      - $signed({r_snap[(k+1)*DW-1], r_snap[k*DW +: DW]});
        assign w_abs            = w_diff[DW] ? -w_diff : w_diff;
        assign w_cell_stable[k] = (w_abs <= c_tol);
        assign w_sign_bits[k]   = ~y_in[(k+1)*DW-1];
    end

    assign w_all_stable = r_snap_vld & (&w_cell_stable);
    assign w_stable_inc = (r_stable_cnt == c_stable) ? r_stable_cnt : r_stable_cnt + 4'd1;
    assign w_stable_nxt = w_all_stable ? w_stable_inc : 4'd0;
    assign w_sweep_nxt  = r_sweep_cnt + 8'd1;
    assign w_conv       = (w_stable_nxt == c_stable);
    assign w_limit      = (w_sweep_nxt == c_max_sweeps);
    assign w_run_sweep  = (r_state == c_run) && sweep_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_run;
            c_run:   if (sweep_end && (w_conv || w_limit)) w_state_nxt = c_done;
            c_done:  if (out_ready) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap       <= '0;
            r_snap_vld   <= 1'b0;
            r_sweep_cnt  <= 8'd0;
            r_stable_cnt <= 4'd0;
            r_out_bits   <= 16'd0;
            r_out_sweeps <= 8'd0;
            r_out_conv   <= 1'b0;
        end else begin
            if ((r_state == c_idle) && start) begin
                r_sweep_cnt  <= 8'd0;
                r_stable_cnt <= 4'd0;
                r_snap_vld   <= 1'b0;
            end
            if (w_run_sweep) begin
                r_snap       <= y_in;
                r_snap_vld   <= 1'b1;
                r_sweep_cnt  <= w_sweep_nxt;
                r_stable_cnt <= w_stable_nxt;
                // Result is captured only on the completing sweep, then frozen.
                if (w_conv || w_limit) begin
                    r_out_bits   <= w_sign_bits;
                    r_out_sweeps <= w_sweep_nxt;
                    r_out_conv   <= w_conv;
                end
            end
        end
    end

    assign busy          = (r_state != c_idle);
    assign out_valid     = (r_state == c_done);
    assign out_bits      = r_out_bits;
    assign out_sweeps    = r_out_sweeps;
    assign out_converged = r_out_conv;

endmodule
`default_nettype wire

// File: tb/tb_cnn_settle_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_settle_detect
//  Purpose  : Directed self-checking bench for cnn_settle_detect.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_settle_detect;

    localparam int DW = 9;
    localparam int W  = 16*DW;

    logic         clk = 1'b0;
    logic         rst_n, start, sweep_end, out_ready;
    logic [W-1:0] y_in;

    logic         d_busy, d_valid, d_conv;
    logic [15:0]  d_bits;
    logic [7:0]   d_sweeps;
    logic         l_busy, l_valid, l_conv;
    logic [15:0]  l_bits;
    logic [7:0]   l_sweeps;
    logic         t_busy, t_valid, t_conv;
    logic [15:0]  t_bits;
    logic [7:0]   t_sweeps;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cnn_settle_detect dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep_end(sweep_end), .y_in(y_in),
        .busy(d_busy), .out_valid(d_valid), .out_ready(out_ready), .out_bits(d_bits),
        .out_sweeps(d_sweeps), .out_converged(d_conv)
    );

    cnn_settle_detect #(.MAX_SWEEPS(8)) dut_lim (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep_end(sweep_end), .y_in(y_in),
        .busy(l_busy), .out_valid(l_valid), .out_ready(out_ready), .out_bits(l_bits),
        .out_sweeps(l_sweeps), .out_converged(l_conv)
    );

    cnn_settle_detect #(.TOL(2)) dut_tol (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep_end(sweep_end), .y_in(y_in),
        .busy(t_busy), .out_valid(t_valid), .out_ready(out_ready), .out_bits(t_bits),
        .out_sweeps(t_sweeps), .out_converged(t_conv)
    );

    function automatic logic [W-1:0] all_cells(input logic [DW-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < 16; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] with_cell(input logic [W-1:0] y, input int k,
                                               input logic [DW-1:0] v);
        logic [W-1:0] r;
        r = y;
        r[(k-1)*DW +: DW] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input logic [W-1:0] y);
        y_in = y; sweep_end = 1'b1; tick(); sweep_end = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; sweep_end = 1'b0; out_ready = 1'b0;
        tick(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", d_busy); end
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", d_valid); end
        n_vec++; if (d_bits !== 16'h0) begin n_bad++; $display("FAIL rst_bits got %h want 0000", d_bits); end
        n_vec++; if (d_sweeps !== 8'd0) begin n_bad++; $display("FAIL rst_sweeps got %0d want 0", d_sweeps); end
        n_vec++; if (d_conv !== 1'b0) begin n_bad++; $display("FAIL rst_conv got %b want 0", d_conv); end
    endtask

    task automatic test_constant();
        do_reset();
        do_start();
        n_vec++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL const_busy got %b want 1", d_busy); end
        sweep(all_cells(DW'(37)));
        sweep(all_cells(DW'(37)));
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL const_early got %b want 0", d_valid); end
        sweep(all_cells(DW'(37)));
        n_vec++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL const_valid got %b want 1", d_valid); end
        n_vec++; if (d_conv !== 1'b1) begin n_bad++; $display("FAIL const_conv got %b want 1", d_conv); end
        n_vec++; if (d_sweeps !== 8'd3) begin n_bad++; $display("FAIL const_sweeps got %0d want 3", d_sweeps); end
        n_vec++; if (d_bits !== 16'hFFFF) begin n_bad++; $display("FAIL const_bits got %h want ffff", d_bits); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL const_drain got %b want 0", d_valid); end
        n_vec++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL const_idle got %b want 0", d_busy); end
    endtask

    task automatic test_mixed();
        logic [W-1:0] base;
        do_reset();
        base = all_cells(DW'(5));
        for (int k = 1; k <= 8; k++) base = with_cell(base, k, DW'(-120));
        do_start();
        sweep(with_cell(base, 4, DW'(-119)));
        sweep(base);
        sweep(base);
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL mixed_early got %b want 0", d_valid); end
        sweep(base);
        n_vec++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL mixed_valid got %b want 1", d_valid); end
        n_vec++; if (d_sweeps !== 8'd4) begin n_bad++; $display("FAIL mixed_sweeps got %0d want 4", d_sweeps); end
        n_vec++; if (d_bits !== 16'hFF00) begin n_bad++; $display("FAIL mixed_bits got %h want ff00", d_bits); end
        n_vec++; if (d_conv !== 1'b1) begin n_bad++; $display("FAIL mixed_conv got %b want 1", d_conv); end
    endtask

    task automatic test_limit();
        do_reset();
        do_start();
        for (int i = 1; i <= 7; i++) sweep(with_cell(all_cells(DW'(0)), 16, (i % 2 == 1) ? DW'(1) : DW'(-1)));
        n_vec++; if (l_valid !== 1'b0) begin n_bad++; $display("FAIL lim_early got %b want 0", l_valid); end
        sweep(with_cell(all_cells(DW'(0)), 16, DW'(-1)));
        n_vec++; if (l_valid !== 1'b1) begin n_bad++; $display("FAIL lim_valid got %b want 1", l_valid); end
        n_vec++; if (l_conv !== 1'b0) begin n_bad++; $display("FAIL lim_conv got %b want 0", l_conv); end
        n_vec++; if (l_sweeps !== 8'd8) begin n_bad++; $display("FAIL lim_sweeps got %0d want 8", l_sweeps); end
        n_vec++; if (l_bits !== 16'h7FFF) begin n_bad++; $display("FAIL lim_bits got %h want 7fff", l_bits); end
    endtask

    task automatic test_tolerance();
        do_reset();
        do_start();
        sweep(with_cell(all_cells(DW'(0)), 3, DW'(10)));
        sweep(with_cell(all_cells(DW'(0)), 3, DW'(12)));
        sweep(with_cell(all_cells(DW'(0)), 3, DW'(10)));
        n_vec++; if (t_valid !== 1'b1) begin n_bad++; $display("FAIL tol2_valid got %b want 1", t_valid); end
        n_vec++; if (t_sweeps !== 8'd3) begin n_bad++; $display("FAIL tol2_sweeps got %0d want 3", t_sweeps); end
        n_vec++; if (t_conv !== 1'b1) begin n_bad++; $display("FAIL tol2_conv got %b want 1", t_conv); end
        n_vec++; if (t_bits !== 16'hFFFF) begin n_bad++; $display("FAIL tol2_bits got %h want ffff", t_bits); end
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL tol0_valid got %b want 0", d_valid); end
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) sweep(with_cell(all_cells(DW'(0)), 3, (i % 2 == 0) ? DW'(10) : DW'(13)));
        n_vec++; if (t_valid !== 1'b0) begin n_bad++; $display("FAIL tol3_valid got %b want 0", t_valid); end
        n_vec++; if (t_busy !== 1'b1) begin n_bad++; $display("FAIL tol3_busy got %b want 1", t_busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) sweep(all_cells(DW'(-5)));
        for (int i = 0; i < 20; i++) begin
            start = i[0]; sweep_end = ~i[0]; y_in = all_cells(DW'(i*7 - 50));
            tick();
            n_vec++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, d_valid); end
            n_vec++; if (d_bits !== 16'h0000) begin n_bad++; $display("FAIL bp_bits[%0d] got %h want 0000", i, d_bits); end
            n_vec++; if (d_sweeps !== 8'd3 || d_conv !== 1'b1) begin
                n_bad++; $display("FAIL bp_fields[%0d] got %0d/%b want 3/1", i, d_sweeps, d_conv); end
        end
        sweep_end = 1'b0; start = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL hs_valid got %b want 0", d_valid); end
        n_vec++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL hs_start_ignored got %b want 0", d_busy); end
        tick();
        start = 1'b0;
        n_vec++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL hs_restart got %b want 1", d_busy); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        do_start();
        for (int i = 1; i <= 5; i++) sweep(with_cell(all_cells(DW'(0)), 1, DW'(i*10)));
        n_vec++; if (d_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", d_busy); end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_vec++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", d_busy); end
        n_vec++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", d_valid); end
        n_vec++; if (d_sweeps !== 8'd0) begin n_bad++; $display("FAIL mid_rst_sweeps got %0d want 0", d_sweeps); end
        do_start();
        for (int i = 0; i < 3; i++) sweep(all_cells(DW'(37)));
        n_vec++; if (d_valid !== 1'b1 || d_sweeps !== 8'd3) begin
            n_bad++; $display("FAIL mid_fresh got %b/%0d want 1/3", d_valid, d_sweeps); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sweep_end = 1'b0; out_ready = 1'b0; y_in = '0;
        test_reset();
        test_constant();
        test_mixed();
        test_limit();
        test_tolerance();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
